// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer,
// flush, bubble zeroing and a saturating downstream stall counter.
module pipe_stage_skid #(
    parameter int                 DATA_W   = 32,
    parameter int                 EXC_W    = 5,
    parameter logic [EXC_W-1:0]   EXC_NONE = '0,
    parameter logic [31:0]        PC_INIT  = 32'hBFC0_0000,
    parameter int                 SKID_EN  = 1,
    parameter int                 CNT_W    = 16
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [31:0]       up_pc,
    input  logic [DATA_W-1:0] up_data,
    input  logic [EXC_W-1:0]  up_exccode,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [31:0]       dn_pc,
    output logic [DATA_W-1:0] dn_data,
    output logic [EXC_W-1:0]  dn_exccode,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

    state_t              state_reg, state_next;
    logic [31:0]         main_pc_reg, main_pc_next;
    logic [DATA_W-1:0]   main_data_reg, main_data_next;
    logic [EXC_W-1:0]    main_exc_reg, main_exc_next;
    logic [31:0]         skid_pc_reg, skid_pc_next;
    logic [DATA_W-1:0]   skid_data_reg, skid_data_next;
    logic [EXC_W-1:0]    skid_exc_reg, skid_exc_next;
    logic [CNT_W-1:0]    stall_cnt_reg, stall_cnt_next;
    logic                up_fire;
    logic                dn_fire;

    assign dn_valid   = (state_reg != ST_EMPTY);
    assign dn_pc      = main_pc_reg;
    assign dn_data    = main_data_reg;
    assign dn_exccode = main_exc_reg;
    assign stall_cnt  = stall_cnt_reg;

    // With the skid buffer, up_ready decodes only the state flops so no
    // combinational path from dn_ready reaches the upstream stage.
    generate
        if (SKID_EN != 0) begin : g_skid
            assign up_ready = (state_reg != ST_SKID);
        end else begin : g_noskid
            assign up_ready = !dn_valid || dn_ready;
        end
    endgenerate

    assign up_fire = up_valid && up_ready;
    assign dn_fire = dn_valid && dn_ready;

    always_comb begin
        state_next     = state_reg;
        main_pc_next   = main_pc_reg;
        main_data_next = main_data_reg;
        main_exc_next  = main_exc_reg;
        skid_pc_next   = skid_pc_reg;
        skid_data_next = skid_data_reg;
        skid_exc_next  = skid_exc_reg;

        case (state_reg)
            ST_EMPTY: begin
                if (up_fire) begin
                    state_next     = ST_FULL;
                    main_pc_next   = up_pc;
                    main_data_next = up_data;
                    main_exc_next  = up_exccode;
                end
            end
            ST_FULL: begin
                if (up_fire && dn_fire) begin
                    main_pc_next   = up_pc;
                    main_data_next = up_data;
                    main_exc_next  = up_exccode;
                end else if (dn_fire) begin
                    // Drained: present a zeroed bubble.
                    state_next     = ST_EMPTY;
                    main_pc_next   = '0;
                    main_data_next = '0;
                    main_exc_next  = EXC_NONE;
                end else if (up_fire) begin
                    state_next     = ST_SKID;
                    skid_pc_next   = up_pc;
                    skid_data_next = up_data;
                    skid_exc_next  = up_exccode;
                end
            end
            ST_SKID: begin
                if (dn_ready) begin
                    state_next     = ST_FULL;
                    main_pc_next   = skid_pc_reg;
                    main_data_next = skid_data_reg;
                    main_exc_next  = skid_exc_reg;
                end
            end
            default: state_next = ST_EMPTY;
        endcase

        if (flush) begin
            state_next     = ST_EMPTY;
            main_pc_next   = PC_INIT;
            main_data_next = '0;
            main_exc_next  = EXC_NONE;
            skid_pc_next   = '0;
            skid_data_next = '0;
            skid_exc_next  = EXC_NONE;
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (dn_valid && !dn_ready && !(&stall_cnt_reg))
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_reg     <= ST_EMPTY;
            main_pc_reg   <= PC_INIT;
            main_data_reg <= '0;
            main_exc_reg  <= EXC_NONE;
            skid_pc_reg   <= '0;
            skid_data_reg <= '0;
            skid_exc_reg  <= EXC_NONE;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            main_pc_reg   <= main_pc_next;
            main_data_reg <= main_data_next;
            main_exc_reg  <= main_exc_next;
            skid_pc_reg   <= skid_pc_next;
            skid_data_reg <= skid_data_next;
            skid_exc_reg  <= skid_exc_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a skid instance for ordering/flush/exception
// scenarios and a no-skid, 4-bit-counter instance for saturation and mid-stall reset.
module tb_pipe_stage_skid;

    logic cpu_clk_50M = 1'b0;
    always #5 cpu_clk_50M = ~cpu_clk_50M;

    localparam logic [31:0] PC_INIT = 32'hBFC0_0000;
    localparam logic [31:0] DMASK   = 32'hA5A5_0000;

    // Skid instance
    logic        cpu_rst, flush, up_valid, up_ready, dn_valid, dn_ready;
    logic [31:0] up_pc, up_data, dn_pc, dn_data;
    logic [4:0]  up_exccode, dn_exccode;
    logic [15:0] stall_cnt;

    // No-skid instance
    logic        rst0, flush0, up_valid0, up_ready0, dn_valid0, dn_ready0;
    logic [31:0] up_pc0, up_data0, dn_pc0, dn_data0;
    logic [4:0]  up_exc0, dn_exc0;
    logic [3:0]  stall_cnt0;

    pipe_stage_skid #(.SKID_EN(1), .CNT_W(16)) u_dut (
        .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready), .up_pc(up_pc), .up_data(up_data),
        .up_exccode(up_exccode), .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_pc(dn_pc),
        .dn_data(dn_data), .dn_exccode(dn_exccode), .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.SKID_EN(0), .CNT_W(4)) u_dut0 (
        .cpu_clk_50M(cpu_clk_50M), .cpu_rst(rst0), .flush(flush0),
        .up_valid(up_valid0), .up_ready(up_ready0), .up_pc(up_pc0), .up_data(up_data0),
        .up_exccode(up_exc0), .dn_valid(dn_valid0), .dn_ready(dn_ready0), .dn_pc(dn_pc0),
        .dn_data(dn_data0), .dn_exccode(dn_exc0), .stall_cnt(stall_cnt0)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic [4:0]  exc;
    } entry_t;

    entry_t sb_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one cycle on the skid instance; entered and left at a falling edge.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [4:0] exc,
                         input logic dr, input logic fl);
        entry_t e;
        up_valid   = v;
        up_pc      = pc;
        up_data    = pc ^ DMASK;
        up_exccode = exc;
        dn_ready   = dr;
        flush      = fl;
        #1;
        if (dn_valid && dn_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 64'(1), 64'(0));
            end else begin
                e = sb_q.pop_front();
                $display("xfer pc=0x%08h data=0x%08h exc=0x%02h", dn_pc, dn_data, dn_exccode);
                check("sb_pc", 64'(dn_pc), 64'(e.pc));
                check("sb_data", 64'(dn_data), 64'(e.data));
                check("sb_exc", 64'(dn_exccode), 64'(e.exc));
            end
        end
        if (fl) begin
            sb_q.delete();
        end else if (v && up_ready) begin
            e.pc   = pc;
            e.data = pc ^ DMASK;
            e.exc  = exc;
            sb_q.push_back(e);
        end
        @(negedge cpu_clk_50M);
    endtask

    task automatic cycle0(input logic v, input logic [31:0] pc, input logic dr, input logic rst);
        up_valid0 = v;
        up_pc0    = pc;
        up_data0  = pc ^ DMASK;
        dn_ready0 = dr;
        rst0      = rst;
        @(negedge cpu_clk_50M);
        $display("nskid pc=0x%08h valid=%0d ready=%0d stall=%0d", dn_pc0, dn_valid0, up_ready0, stall_cnt0);
    endtask

    initial begin
        cpu_rst = 1'b1; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0;
        up_pc = '0; up_data = '0; up_exccode = '0;
        rst0 = 1'b1; flush0 = 1'b0; up_valid0 = 1'b0; dn_ready0 = 1'b0;
        up_pc0 = '0; up_data0 = '0; up_exc0 = '0;
        repeat (2) @(negedge cpu_clk_50M);
        cpu_rst = 1'b0;
        rst0    = 1'b0;
        #1;

        // Reset values
        check("rst_valid", 64'(dn_valid), 64'(0));
        check("rst_pc", 64'(dn_pc), 64'(PC_INIT));
        check("rst_data", 64'(dn_data), 64'(0));
        check("rst_exc", 64'(dn_exccode), 64'(0));
        check("rst_up_ready", 64'(up_ready), 64'(1));
        check("rst_stall", 64'(stall_cnt), 64'(0));
        @(negedge cpu_clk_50M);

        // Streaming: dn trails up by one cycle, no back-pressure
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'h100 + 32'(4 * i), 5'd0, 1'b1, 1'b0);
            check("stream_valid", 64'(dn_valid), 64'(1));
            check("stream_pc", 64'(dn_pc), 64'(32'h100 + 32'(4 * i)));
            check("stream_up_ready", 64'(up_ready), 64'(1));
        end
        cycle(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
        check("bubble_valid", 64'(dn_valid), 64'(0));
        check("bubble_pc", 64'(dn_pc), 64'(0));
        check("bubble_data", 64'(dn_data), 64'(0));

        // Skid fill and drain
        cycle(1'b1, 32'h200, 5'd0, 1'b1, 1'b0);
        cycle(1'b1, 32'h204, 5'd0, 1'b0, 1'b0);
        check("skid_up_ready", 64'(up_ready), 64'(0));
        check("skid_head_pc", 64'(dn_pc), 64'(32'h200));
        cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        check("skid_stall", 64'(stall_cnt), 64'(2));
        check("skid_hold_ready", 64'(up_ready), 64'(0));
        cycle(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
        check("skid_second_pc", 64'(dn_pc), 64'(32'h204));
        check("skid_ready_back", 64'(up_ready), 64'(1));
        cycle(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
        check("skid_drained", 64'(dn_valid), 64'(0));

        // Flush while in SKID
        cycle(1'b1, 32'h2F0, 5'd0, 1'b1, 1'b0);
        cycle(1'b1, 32'h2F4, 5'd0, 1'b0, 1'b0);
        cycle(1'b1, 32'h300, 5'd0, 1'b0, 1'b1);
        check("flush_valid", 64'(dn_valid), 64'(0));
        check("flush_pc", 64'(dn_pc), 64'(PC_INIT));
        check("flush_up_ready", 64'(up_ready), 64'(1));
        check("flush_stall_kept", 64'(stall_cnt), 64'(4));
        cycle(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
        check("flush_no_300", 64'(dn_valid), 64'(0));

        // Flush while FULL: head still leaves, concurrent up transfer dropped
        cycle(1'b1, 32'h310, 5'd0, 1'b1, 1'b0);
        cycle(1'b1, 32'h314, 5'd0, 1'b1, 1'b1);
        check("flushf_valid", 64'(dn_valid), 64'(0));
        check("flushf_pc", 64'(dn_pc), 64'(PC_INIT));
        cycle(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
        check("flushf_no_314", 64'(dn_valid), 64'(0));

        // Exception code pass-through
        cycle(1'b1, 32'h400, 5'h0D, 1'b1, 1'b0);
        check("exc_code", 64'(dn_exccode), 64'(5'h0D));
        check("exc_pc", 64'(dn_pc), 64'(32'h400));
        cycle(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
        check("exc_bubble", 64'(dn_exccode), 64'(0));
        check("exc_bubble_valid", 64'(dn_valid), 64'(0));
        check("sb_empty_end", 64'(sb_q.size()), 64'(0));

        // No-skid instance: back-pressure, saturation, reset mid-stall
        cycle0(1'b1, 32'h500, 1'b0, 1'b0);
        check("ns_full_valid", 64'(dn_valid0), 64'(1));
        check("ns_full_ready", 64'(up_ready0), 64'(0));
        for (int i = 0; i < 20; i++) begin
            cycle0(1'b1, 32'h504 + 32'(4 * i), 1'b0, 1'b0);
            if (i == 13) check("ns_stall_14", 64'(stall_cnt0), 64'(4'hE));
        end
        check("ns_hold_pc", 64'(dn_pc0), 64'(32'h500));
        check("ns_hold_ready", 64'(up_ready0), 64'(0));
        check("ns_stall_sat", 64'(stall_cnt0), 64'(4'hF));
        cycle0(1'b1, 32'h580, 1'b0, 1'b1);
        check("ns_rst_valid", 64'(dn_valid0), 64'(0));
        check("ns_rst_pc", 64'(dn_pc0), 64'(PC_INIT));
        check("ns_rst_data", 64'(dn_data0), 64'(0));
        check("ns_rst_exc", 64'(dn_exc0), 64'(0));
        check("ns_rst_stall", 64'(stall_cnt0), 64'(0));
        check("ns_rst_ready", 64'(up_ready0), 64'(1));
        cycle0(1'b1, 32'h600, 1'b1, 1'b0);
        check("ns_pass_pc", 64'(dn_pc0), 64'(32'h600));
        check("ns_pass_ready", 64'(up_ready0), 64'(1));
        cycle0(1'b1, 32'h604, 1'b1, 1'b0);
        check("ns_replace_pc", 64'(dn_pc0), 64'(32'h604));
        check("ns_replace_data", 64'(dn_data0), 64'(32'h604 ^ DMASK));
        cycle0(1'b0, 32'h0, 1'b1, 1'b0);
        check("ns_drain_valid", 64'(dn_valid0), 64'(0));
        check("ns_drain_pc", 64'(dn_pc0), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
